// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath: sequences fetch/decode/execute
// and counts retired instructions. Outputs decode from the state register (plus mem_ready in fetch).
module multicycle_control #(
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pcWrite,
  output logic             pcWriteCond,
  output logic             iorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             memToReg,
  output logic             regDst,
  output logic             regWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [1:0]       pcSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t             state_q, state_d;
  logic               illegal_op_q, illegal_op_d;
  logic [RET_W-1:0]   retired_q, retired_d;
  logic               retire;

  always_comb begin
    state_d      = S_IDLE;
    illegal_op_d = 1'b0;
    case (state_q)
      S_IDLE:   state_d = en ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d      = S_FETCH;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // Only completing states count; DECODE->FETCH on an illegal opcode is excluded.
  always_comb begin
    retire = (state_d == S_FETCH) &&
             (state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB});
    retired_d = retired_q + RET_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      illegal_op_q <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
      retired_q    <= retired_d;
    end
  end

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSource    = 2'b00;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = mem_ready;
        pcWrite = mem_ready;
      end
      S_DECODE: aluSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      S_EXEC: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
      end
      S_JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
      end
      S_ADDIWB: regWrite = 1'b1;
      default: ;
    endcase
  end

  assign state      = state_q;
  assign illegal_op = illegal_op_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (RET_W=4): walks every instruction class, stalls,
// an illegal opcode, reset mid-stall and retired-counter wrap against a per-cycle expected queue.
module tb_multicycle_control;

  localparam int W = 25;  // {state[3:0], ctrl[15:0], illegal_op, retired[3:0]}

  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3,
                         MEMRD = 4'd4, MEMWB = 4'd5, MEMWR = 4'd6, EXEC = 4'd7,
                         ALUWB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, ADDIEX = 4'd11,
                         ADDIWB = 4'd12;

  // ctrl bit order: pcWrite pcWriteCond iorD memRead memWrite irWrite memToReg regDst
  //                 regWrite aluSrcA aluSrcB[1:0] aluOp[1:0] pcSource[1:0]
  localparam logic [15:0] C_IDLE    = 16'h0000;
  localparam logic [15:0] C_FETCH_R = 16'h9410;
  localparam logic [15:0] C_FETCH_S = 16'h1010;
  localparam logic [15:0] C_DECODE  = 16'h0030;
  localparam logic [15:0] C_MEMADR  = 16'h0060;
  localparam logic [15:0] C_MEMRD   = 16'h3000;
  localparam logic [15:0] C_MEMWB   = 16'h0280;
  localparam logic [15:0] C_MEMWR   = 16'h2800;
  localparam logic [15:0] C_EXEC    = 16'h0048;
  localparam logic [15:0] C_ALUWB   = 16'h0180;
  localparam logic [15:0] C_BRANCH  = 16'h4045;
  localparam logic [15:0] C_JUMP    = 16'h8002;
  localparam logic [15:0] C_ADDIEX  = 16'h0060;
  localparam logic [15:0] C_ADDIWB  = 16'h0080;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                         OP_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       reset, en, mem_ready;
  logic [5:0] opcode;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regDst, regWrite, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;
  logic       illegal_op;
  logic [3:0] retired;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control #(.RET_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .opcode(opcode), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .state(state), .illegal_op(illegal_op), .retired(retired)
  );

  always #5 clk = ~clk;

  // Drive inputs for one cycle, check the outputs of the current state, then advance one edge.
  task automatic cyc(input string tag, input logic e, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic [15:0] ctrl, input logic ill,
                     input logic [3:0] ret);
    logic [W-1:0] want, got;
    en = e; opcode = op; mem_ready = mr;
    exp_q.push_back({st, ctrl, ill, ret});
    #1;
    want = exp_q.pop_front();
    got  = {state, pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
            regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegal_op, retired};
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed st=%0d ctrl=%h ill=%b ret=%0d, expected st=%0d ctrl=%h ill=%b ret=%0d",
             tag, got[24:21], got[20:5], got[4], got[3:0],
             want[24:21], want[20:5], want[4], want[3:0]);
    end
    n_checks++;
    assert (!(memRead && memWrite) && !(regWrite && pcWrite)) else begin
      n_fail++;
      $error("FAIL %s_mutex: observed memRead=%b memWrite=%b regWrite=%b pcWrite=%b, expected no pair both 1",
             tag, memRead, memWrite, regWrite, pcWrite);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; opcode = OP_R; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_idle", 1'b1, OP_R, 1'b0, IDLE, C_IDLE, 1'b0, 4'd0);
    reset = 1'b0;

    // IDLE holds without en, then an R-type with en dropped mid-instruction
    cyc("idle_hold",   1'b0, OP_R, 1'b1, IDLE,   C_IDLE,    1'b0, 4'd0);
    cyc("r_idle",      1'b1, OP_R, 1'b1, IDLE,   C_IDLE,    1'b0, 4'd0);
    cyc("r_fetch",     1'b0, OP_R, 1'b1, FETCH,  C_FETCH_R, 1'b0, 4'd0);
    cyc("r_decode",    1'b0, OP_R, 1'b1, DECODE, C_DECODE,  1'b0, 4'd0);
    cyc("r_exec",      1'b0, OP_R, 1'b1, EXEC,   C_EXEC,    1'b0, 4'd0);
    cyc("r_aluwb",     1'b0, OP_R, 1'b1, ALUWB,  C_ALUWB,   1'b0, 4'd0);

    // lw with a fetch stall and a 3-cycle memory stall
    cyc("lw_fetch_st", 1'b0, OP_LW, 1'b0, FETCH,  C_FETCH_S, 1'b0, 4'd1);
    cyc("lw_fetch",    1'b0, OP_LW, 1'b1, FETCH,  C_FETCH_R, 1'b0, 4'd1);
    cyc("lw_decode",   1'b0, OP_LW, 1'b1, DECODE, C_DECODE,  1'b0, 4'd1);
    cyc("lw_memadr",   1'b0, OP_LW, 1'b1, MEMADR, C_MEMADR,  1'b0, 4'd1);
    for (int i = 0; i < 3; i++)
      cyc("lw_memrd_st", 1'b0, OP_LW, 1'b0, MEMRD, C_MEMRD, 1'b0, 4'd1);
    cyc("lw_memrd",    1'b0, OP_LW, 1'b1, MEMRD,  C_MEMRD,   1'b0, 4'd1);
    cyc("lw_memwb",    1'b0, OP_LW, 1'b1, MEMWB,  C_MEMWB,   1'b0, 4'd1);

    cyc("beq_fetch",   1'b0, OP_BEQ, 1'b1, FETCH,  C_FETCH_R, 1'b0, 4'd2);
    cyc("beq_decode",  1'b0, OP_BEQ, 1'b1, DECODE, C_DECODE,  1'b0, 4'd2);
    cyc("beq_branch",  1'b0, OP_BEQ, 1'b1, BRANCH, C_BRANCH,  1'b0, 4'd2);
    cyc("j_fetch",     1'b0, OP_J,   1'b1, FETCH,  C_FETCH_R, 1'b0, 4'd3);
    cyc("j_decode",    1'b0, OP_J,   1'b1, DECODE, C_DECODE,  1'b0, 4'd3);
    cyc("j_jump",      1'b0, OP_J,   1'b1, JUMP,   C_JUMP,    1'b0, 4'd3);

    // illegal opcode: flagged for one cycle on return to FETCH, not retired
    cyc("bad_fetch",   1'b0, OP_BAD, 1'b1, FETCH,  C_FETCH_R, 1'b0, 4'd4);
    cyc("bad_decode",  1'b0, OP_BAD, 1'b1, DECODE, C_DECODE,  1'b0, 4'd4);
    cyc("bad_flag",    1'b0, OP_SW,  1'b1, FETCH,  C_FETCH_R, 1'b1, 4'd4);

    cyc("sw_decode",   1'b0, OP_SW, 1'b1, DECODE, C_DECODE, 1'b0, 4'd4);
    cyc("sw_memadr",   1'b0, OP_SW, 1'b1, MEMADR, C_MEMADR, 1'b0, 4'd4);
    cyc("sw_memwr_st", 1'b0, OP_SW, 1'b0, MEMWR,  C_MEMWR,  1'b0, 4'd4);
    cyc("sw_memwr_st", 1'b0, OP_SW, 1'b0, MEMWR,  C_MEMWR,  1'b0, 4'd4);
    cyc("sw_memwr",    1'b0, OP_SW, 1'b1, MEMWR,  C_MEMWR,  1'b0, 4'd4);

    // reset while MEMWR is stalled
    cyc("sw2_fetch",   1'b0, OP_SW, 1'b1, FETCH,  C_FETCH_R, 1'b0, 4'd5);
    cyc("sw2_decode",  1'b0, OP_SW, 1'b1, DECODE, C_DECODE,  1'b0, 4'd5);
    cyc("sw2_memadr",  1'b0, OP_SW, 1'b1, MEMADR, C_MEMADR,  1'b0, 4'd5);
    reset = 1'b1;
    cyc("sw2_memwr_rst", 1'b0, OP_SW, 1'b0, MEMWR, C_MEMWR,  1'b0, 4'd5);
    reset = 1'b0;
    cyc("post_rst",    1'b1, OP_ADDI, 1'b0, IDLE,  C_IDLE,   1'b0, 4'd0);

    // 16 addi instructions wrap the 4-bit retired counter
    for (int i = 0; i < 16; i++) begin
      cyc("addi_fetch",  1'b0, OP_ADDI, 1'b1, FETCH,  C_FETCH_R, 1'b0, 4'(i));
      cyc("addi_decode", 1'b0, OP_ADDI, 1'b1, DECODE, C_DECODE,  1'b0, 4'(i));
      cyc("addi_ex",     1'b0, OP_ADDI, 1'b1, ADDIEX, C_ADDIEX,  1'b0, 4'(i));
      cyc("addi_wb",     1'b0, OP_ADDI, 1'b1, ADDIWB, C_ADDIWB,  1'b0, 4'(i));
    end
    cyc("wrap_fetch",  1'b0, OP_ADDI, 1'b0, FETCH, C_FETCH_S, 1'b0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
